// File: rtl/imem_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg: shared constants and types for the instruction fetch controller.
//   DATA_WIDTH    - memory byte-lane width in bits
//   INSTR_WIDTH   - instruction / PC width in bits
//   fetch_state_e - FETCH (byte requests active) / HOLD (no free buffer slot)
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int INSTR_WIDTH = 32;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if: memory bus and instruction handshake of the fetch unit.
//   mem_req_o / mem_addr_o  - byte read request and address (fetch -> memory)
//   mem_rdata_i             - read byte, one cycle after its request
//   instr_o / instr_pc_o    - head-of-buffer instruction and its PC
//   instr_valid_o           - instruction outputs are valid
//   instr_ready_i           - consumer accepts
// Handshake: a transfer happens in every cycle where instr_valid_o and
// instr_ready_i are both 1. While valid is 1 and ready is 0, instr_o and
// instr_pc_o hold stable. Valid never waits on ready.
// Modports: master = fetch controller, slave = memory + consumer side.
// -----------------------------------------------------------------------------
interface imem_fetch_ctrl_if
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH  = imem_pkg::DATA_WIDTH,
  parameter int INSTR_WIDTH = imem_pkg::INSTR_WIDTH
);

  logic                   mem_req_o;
  logic [INSTR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]  mem_rdata_i;
  logic [INSTR_WIDTH-1:0] instr_o;
  logic [INSTR_WIDTH-1:0] instr_pc_o;
  logic                   instr_valid_o;
  logic                   instr_ready_i;

  modport master (
    output mem_req_o, mem_addr_o, instr_o, instr_pc_o, instr_valid_o,
    input  mem_rdata_i, instr_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, instr_o, instr_pc_o, instr_valid_o,
    output mem_rdata_i, instr_ready_i
  );

endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo: prefetch buffer holding {pc, instr} entries.
//   clk_i, rst_ni - clock, synchronous active-low reset
//   flush_i       - empty the buffer (wins over push/pop)
//   push_i        - write push_data_i; legal when full only together with pop_i
//   pop_i         - drop the head entry (caller guarantees not empty)
//   pop_data_o    - head entry
//   count_o       - number of stored entries
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count_q covers them.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl: byte-serial instruction fetch with a small prefetch buffer.
// Each instruction is read as four big-endian bytes (PC..PC+3), one request per
// cycle; the assembled word is pushed into fetch_fifo and offered on the
// valid/ready instruction port.
//   clk_i, rst_ni   - clock, synchronous active-low reset
//   redirect_i      - flush and restart fetching at redirect_pc_i
//   redirect_pc_i   - restart PC (used unmodified)
//   bus (master)    - memory request/response and instruction handshake
//   state_o         - current FSM state (debug)
//   fifo_count_o    - prefetch buffer occupancy (debug)
// Optional macro FETCH_BYPASS_EN: when the buffer is empty, the word completing
// this cycle is presented combinationally; if accepted it is never pushed.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH  = imem_pkg::DATA_WIDTH,
  parameter int INSTR_WIDTH = imem_pkg::INSTR_WIDTH,
  parameter int FIFO_DEPTH  = 2,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   redirect_i,
  input  logic [INSTR_WIDTH-1:0] redirect_pc_i,
  imem_fetch_ctrl_if.master      bus,
  output fetch_state_e           state_o,
  output logic [CW-1:0]          fifo_count_o
);

  localparam int NBYTES = INSTR_WIDTH / DATA_WIDTH;
  localparam int BW     = $clog2(NBYTES);
  localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);

  fetch_state_e           state_q, state_d;
  logic [INSTR_WIDTH-1:0] pc_q, pc_d;            // PC of the instruction being requested
  logic [BW-1:0]          req_cnt_q, req_cnt_d;  // byte index requested this cycle
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BW-1:0]          rsp_idx_q, rsp_idx_d;  // byte index arriving this cycle
  logic [INSTR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;    // PC of the word being assembled
  logic [INSTR_WIDTH-1:0] asm_q, asm_d;          // captured bytes, shifted in MSB first

  logic [CW-1:0]            fifo_count;
  logic [2*INSTR_WIDTH-1:0] fifo_head;
  logic                     fifo_empty, fifo_push, fifo_pop;
  logic                     complete, byp_valid, transfer, can_start, mem_req;
  logic [INSTR_WIDTH-1:0]   word_done, out_instr, out_pc;
  logic                     out_valid;
  logic [CW:0]              occ;

  // Final byte of an instruction arrives this cycle.
  assign complete  = rsp_valid_q && (rsp_idx_q == LAST);
  assign word_done = {asm_q[INSTR_WIDTH-DATA_WIDTH-1:0], bus.mem_rdata_i};
  assign fifo_empty = (fifo_count == '0);

`ifdef FETCH_BYPASS_EN
  assign byp_valid = complete && fifo_empty;
`else
  assign byp_valid = 1'b0;
`endif

  assign out_valid = !fifo_empty || byp_valid;
  assign out_instr = fifo_empty ? word_done : fifo_head[INSTR_WIDTH-1:0];
  assign out_pc    = fifo_empty ? rsp_pc_q  : fifo_head[2*INSTR_WIDTH-1:INSTR_WIDTH];
  assign transfer  = out_valid && bus.instr_ready_i;
  assign fifo_pop  = !fifo_empty && bus.instr_ready_i;
  // A redirect discards the completing word; an accepted bypass needs no storage.
  assign fifo_push = complete && !redirect_i && !(byp_valid && bus.instr_ready_i);

  // Slots claimed = buffered + the word in assembly (including the one
  // completing now), minus whatever leaves this cycle.
  assign occ       = {1'b0, fifo_count} + (CW+1)'(rsp_valid_q) - (CW+1)'(transfer);
  assign can_start = (occ < (CW+1)'(FIFO_DEPTH));

  fetch_fifo #(
    .WIDTH (2 * INSTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (redirect_i),
    .push_i      (fifo_push),
    .push_data_i ({rsp_pc_q, word_done}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count)
  );

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // FSM: next state. A new instruction only starts at byte 0.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH:   if (req_cnt_q == '0 && !can_start) state_d = HOLD;
        HOLD:    if (can_start) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  // FSM: outputs. The redirect cycle issues no request; the restart
  // request goes out in the following cycle.
  always_comb begin
    mem_req = 1'b0;
    if (rst_ni && !redirect_i && state_q == FETCH && (req_cnt_q != '0 || can_start))
      mem_req = 1'b1;
    bus.mem_req_o     = mem_req;
    bus.mem_addr_o    = rst_ni ? pc_q + INSTR_WIDTH'(req_cnt_q) : '0;
    bus.instr_valid_o = rst_ni && out_valid;
    bus.instr_o       = (rst_ni && out_valid) ? out_instr : '0;
    bus.instr_pc_o    = (rst_ni && out_valid) ? out_pc    : '0;
  end

  // Datapath next state
  always_comb begin
    pc_d        = pc_q;
    req_cnt_d   = req_cnt_q;
    rsp_valid_d = mem_req;
    rsp_idx_d   = req_cnt_q;
    rsp_pc_d    = rsp_pc_q;
    asm_d       = asm_q;
    if (rsp_valid_q) asm_d = word_done;
    if (redirect_i) begin
      pc_d        = redirect_pc_i;
      req_cnt_d   = '0;
      rsp_valid_d = 1'b0;
    end else if (mem_req) begin
      rsp_pc_d  = pc_q;
      req_cnt_d = req_cnt_q + BW'(1);
      // Wraps modulo 2^INSTR_WIDTH.
      if (req_cnt_q == LAST) pc_d = pc_q + INSTR_WIDTH'(NBYTES);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q        <= '0;
      req_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_pc_q    <= '0;
      asm_q       <= '0;
    end else begin
      pc_q        <= pc_d;
      req_cnt_q   <= req_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_pc_q    <= rsp_pc_d;
      asm_q       <= asm_d;
    end
  end

  assign state_o      = state_q;
  assign fifo_count_o = fifo_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int FV = 4;  // first valid cycle after the byte-0 request
`else
  localparam int FV = 5;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_ni;
  logic         redirect_i;
  logic [31:0]  redirect_pc_i;
  fetch_state_e state_o;
  logic [1:0]   fifo_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  imem_fetch_ctrl_if #(.DATA_WIDTH(8), .INSTR_WIDTH(32)) bus ();

  imem_fetch_ctrl #(
    .DATA_WIDTH  (8),
    .INSTR_WIDTH (32),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .bus           (bus),
    .state_o       (state_o),
    .fifo_count_o  (fifo_count_o)
  );

  // memory model: fixed program at 0..7, address-derived bytes elsewhere
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] tbl [8];
    tbl = '{8'h13, 8'h00, 8'h00, 8'h93, 8'h00, 8'h40, 8'h01, 8'h13};
    if (a < 32'd8) return tbl[a[2:0]];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk)
    bus.mem_rdata_i <= bus.mem_req_o ? mem_byte(bus.mem_addr_o) : 8'h00;

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench inside cycle 0 (first cycle with rst_ni=1).
  task automatic do_reset();
    rst_ni            = 1'b0;
    redirect_i        = 1'b0;
    redirect_pc_i     = 32'h0;
    bus.instr_ready_i = 1'b1;
    repeat (3) next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni            = 1'b0;
    redirect_i        = 1'b1;
    redirect_pc_i     = 32'h100;
    bus.instr_ready_i = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    n_tests++; if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req_o); end
    n_tests++; if (bus.mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr_o); end
    n_tests++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.instr_valid_o); end
    n_tests++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.instr_o); end
    n_tests++; if (bus.instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.instr_pc_o); end
    n_tests++; if (state_o !== FETCH) begin n_fail++; $display("FAIL reset_state: got %0d want FETCH", state_o); end
    n_tests++; if (fifo_count_o !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
  endtask

  task automatic test_basic();
    logic        exp_v;
    logic [31:0] exp_i, exp_pc;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      if (c < 8) begin
        n_tests++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'(c)) begin
          n_fail++; $display("FAIL basic_req c%0d: got req=%0b addr=%h want req=1 addr=%h", c, bus.mem_req_o, bus.mem_addr_o, 32'(c));
        end
      end
      exp_v = (c == FV) || (c == FV + 4);
      n_tests++;
      if (bus.instr_valid_o !== exp_v) begin
        n_fail++; $display("FAIL basic_valid c%0d: got %0b want %0b", c, bus.instr_valid_o, exp_v);
      end
      if (exp_v) begin
        exp_i  = (c == FV) ? 32'h13000093 : 32'h00400113;
        exp_pc = (c == FV) ? 32'h0 : 32'h4;
        n_tests++;
        if (bus.instr_o !== exp_i || bus.instr_pc_o !== exp_pc) begin
          n_fail++; $display("FAIL basic_instr c%0d: got %h@%h want %h@%h", c, bus.instr_o, bus.instr_pc_o, exp_i, exp_pc);
        end
      end
`ifdef FETCH_BYPASS_EN
      n_tests++;
      if (fifo_count_o !== 2'd0) begin n_fail++; $display("FAIL bypass_count c%0d: got %0d want 0", c, fifo_count_o); end
`endif
    end
  endtask

  task automatic test_backpressure();
    int req_n;
    req_n = 0;
    do_reset();
    bus.instr_ready_i = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c > 0) next_cycle();
      bus.instr_ready_i = (c == 20);
      @(negedge clk);
      if (c < 20 && bus.mem_req_o === 1'b1) begin
        n_tests++;
        if (bus.mem_addr_o !== 32'(req_n)) begin
          n_fail++; $display("FAIL bp_addr c%0d: got %h want %h", c, bus.mem_addr_o, 32'(req_n));
        end
        req_n++;
      end
      if (c >= 8 && c < 20) begin
        n_tests++;
        if (bus.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold_req c%0d: got %0b want 0", c, bus.mem_req_o); end
      end
      if (c >= FV && c <= 20) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h13000093 || bus.instr_pc_o !== 32'h0) begin
          n_fail++; $display("FAIL bp_stable c%0d: got v=%0b %h@%h want 1 13000093@0", c, bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
      end
      if (c == 19) begin
        n_tests++;
        if (req_n != 8) begin n_fail++; $display("FAIL bp_req_count: got %0d want 8", req_n); end
        n_tests++;
        if (state_o !== HOLD) begin n_fail++; $display("FAIL bp_state: got %0d want HOLD", state_o); end
      end
      if (c == 21) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h00400113 || bus.instr_pc_o !== 32'h4) begin
          n_fail++; $display("FAIL bp_second c21: got v=%0b %h@%h want 1 00400113@4", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
        n_tests++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h8) begin
          n_fail++; $display("FAIL bp_resume c21: got req=%0b addr=%h want 1 8", bus.mem_req_o, bus.mem_addr_o);
        end
      end
    end
    bus.instr_ready_i = 1'b1;
  endtask

  task automatic test_redirect_partial();
    do_reset();
    for (int c = 0; c <= 3 + FV; c++) begin
      if (c > 0) next_cycle();
      redirect_i    = (c == 2);
      redirect_pc_i = 32'h100;
      @(negedge clk);
      if (c == 3) begin
        n_tests++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h100) begin
          n_fail++; $display("FAIL rdp_addr: got req=%0b addr=%h want 1 100", bus.mem_req_o, bus.mem_addr_o);
        end
        n_tests++;
        if (fifo_count_o !== 2'd0) begin n_fail++; $display("FAIL rdp_count: got %0d want 0", fifo_count_o); end
      end
      if (c >= 3 && c < 3 + FV) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdp_novalid c%0d: got %0b want 0", c, bus.instr_valid_o); end
      end
      if (c == 3 + FV) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h5A5B5859 || bus.instr_pc_o !== 32'h100) begin
          n_fail++; $display("FAIL rdp_instr: got v=%0b %h@%h want 1 5a5b5859@100", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
      end
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_redirect_transfer();
    do_reset();
    for (int c = 0; c <= 2 * FV + 1; c++) begin
      if (c > 0) next_cycle();
      redirect_i    = (c == FV);
      redirect_pc_i = 32'h40;
      @(negedge clk);
      if (c == FV) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_pc_o !== 32'h0) begin
          n_fail++; $display("FAIL rdt_xfer: got v=%0b pc=%h want 1 0", bus.instr_valid_o, bus.instr_pc_o);
        end
      end
      if (c == FV + 1) begin
        n_tests++;
        if (fifo_count_o !== 2'd0) begin n_fail++; $display("FAIL rdt_count: got %0d want 0", fifo_count_o); end
        n_tests++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h40) begin
          n_fail++; $display("FAIL rdt_addr: got req=%0b addr=%h want 1 40", bus.mem_req_o, bus.mem_addr_o);
        end
      end
      if (c > FV && c < 2 * FV + 1) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rdt_novalid c%0d: got %0b want 0", c, bus.instr_valid_o); end
      end
      if (c == 2 * FV + 1) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h1A1B1819 || bus.instr_pc_o !== 32'h40) begin
          n_fail++; $display("FAIL rdt_instr: got v=%0b %h@%h want 1 1a1b1819@40", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
      end
    end
    redirect_i = 1'b0;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] exp_a;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) next_cycle();
      redirect_i    = (c == 0);
      redirect_pc_i = 32'hFFFFFFFC;
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        exp_a = (c == 5) ? 32'h0 : 32'hFFFFFFFC + 32'(c - 1);
        n_tests++;
        if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== exp_a) begin
          n_fail++; $display("FAIL wrap_addr c%0d: got req=%0b addr=%h want 1 %h", c, bus.mem_req_o, bus.mem_addr_o, exp_a);
        end
      end
      if (c == 1 + FV) begin
        n_tests++;
        if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'hA6A7A4A5 || bus.instr_pc_o !== 32'hFFFFFFFC) begin
          n_fail++; $display("FAIL wrap_instr: got v=%0b %h@%h want 1 a6a7a4a5@fffffffc", bus.instr_valid_o, bus.instr_o, bus.instr_pc_o);
        end
      end
    end
    redirect_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_partial();
    test_redirect_transfer();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001: Parameter DATA_WIDTH, default 8, is the memory byte-lane width in bits.
REQ-002: Parameter INSTR_WIDTH, default 32, is the instruction and PC width in bits.
REQ-003: Parameter FIFO_DEPTH, default 2, is the number of prefetch buffer entries; legal values are 2 and 4.
REQ-004: clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005: rst_ni  input  1  reset, synchronous and active-low.
REQ-006: redirect_i  input  1  flush request; the next fetch starts from redirect_pc_i.
REQ-007: redirect_pc_i  input  INSTR_WIDTH  target PC, sampled when redirect_i=1.
REQ-008: mem_req_o  output  1  byte read request to instruction memory this cycle.
REQ-009: mem_addr_o  output  INSTR_WIDTH  byte address of the request.
REQ-010: mem_rdata_i  input  DATA_WIDTH  read byte, returned exactly one cycle after its request.
REQ-011: instr_o  output  INSTR_WIDTH  head-of-buffer instruction.
REQ-012: instr_pc_o  output  INSTR_WIDTH  PC of instr_o.
REQ-013: instr_valid_o  output  1  instr_o/instr_pc_o are valid.
REQ-014: instr_ready_i  input  1  consumer accepts; a transfer occurs when valid and ready are both 1.

Function
REQ-015: FSM states are FETCH (byte requests active) and HOLD (no free slot); a redirect in either state clears the byte counter and enters FETCH.
REQ-016: Byte k (k=0..3) of an instruction at PC is requested in cycle N+k with mem_addr_o=PC+k and mem_req_o=1.
REQ-017: Assembly is big-endian: the byte at PC forms bits [31:24], and the byte at PC+3 forms bits [7:0].
REQ-018: The completed word and its PC are pushed at the end of cycle N+4, and instr_valid_o=1 from cycle N+5.
REQ-019: Byte 0 of the next instruction may be requested in cycle N+4, giving a sustained rate of one instruction per 4 cycles.
REQ-020: A new instruction is started only if the buffer count plus the in-progress assembly is less than FIFO_DEPTH, with a same-cycle pop counted as freeing a slot; otherwise the FSM enters HOLD with mem_req_o=0.
REQ-021: The fetch PC advances by 4 modulo 2^INSTR_WIDTH, so PC 0xFFFFFFFC is followed by 0x00000000.
REQ-022: On redirect_i=1, the buffer is emptied, the in-flight byte and partial word are discarded, and instr_valid_o=0 in the next cycle.
REQ-023: On redirect_i=1, byte 0 is requested at redirect_pc_i in the cycle after the redirect.
REQ-024: When redirect_i and a transfer coincide, the redirect wins; the transferred instruction counts as consumed and nothing else is retained.
REQ-025: redirect_pc_i is used unmodified; alignment is the consumer's responsibility.
REQ-026: instr_o and instr_pc_o hold stable while instr_valid_o=1 and instr_ready_i=0.

Reset
REQ-027: While rst_ni=0, the outputs are mem_req_o=0, mem_addr_o=0, instr_valid_o=0, instr_o=0 and instr_pc_o=0; the buffer is emptied, the fetch PC is set to 0, and the state is FETCH.
REQ-028: Byte 0 at address 0 is requested in the first cycle with rst_ni=1.
REQ-029: Reset asserted mid-assembly discards the partial word with no push.
REQ-030: redirect_i is ignored while rst_ni=0.

Configuration
REQ-031: With macro FETCH_BYPASS_EN defined and the buffer empty, the completing word (three captured bytes concatenated with mem_rdata_i) is driven combinationally in cycle N+4 with instr_valid_o=1.
REQ-032: With FETCH_BYPASS_EN defined and the bypass transfer accepted, no push occurs.
REQ-033: Without FETCH_BYPASS_EN, the first valid cycle is N+5 in all cases.

Structure
REQ-034: Package imem_pkg holds the DATA_WIDTH and INSTR_WIDTH constants and the fetch_state_e enum {FETCH, HOLD}.
REQ-035: The prefetch buffer is the sub-module fetch_fifo, storing {pc, instr}, with push/pop/count ports and simultaneous push and pop legal when full.

Verification
REQ-036: Memory bytes 0x00..0x07 = 13 00 00 93 00 40 01 13, reset release at cycle 0, ready=1 -> instr 0x13000093/pc 0 valid at cycle 5, and 0x00400113/pc 4 valid at cycle 9.
REQ-037: ready=0 for 20 cycles, FIFO_DEPTH=2 -> exactly 8 byte requests (addresses 0..7), then mem_req_o=0, and instr_o holds pc 0.
REQ-038: Redirect to 0x100 during the request of byte 2 -> no push for the partial word, instr_valid_o=0 next cycle, and the next address is 0x100.
REQ-039: Redirect to 0x40 in the same cycle as a transfer of pc 0 -> buffer empty, and the first subsequent valid has pc 0x40.
REQ-040: Redirect to 0xFFFFFFFC -> instruction at 0xFFFFFFFC, then the next fetch address is 0x00000000.
REQ-041: Build with FETCH_BYPASS_EN -> first instruction valid at cycle 4, and the buffer count stays 0 with ready=1.
